// File: rtl/mdu_if.sv
//==============================================================================
// Module      : mdu_if
// Description : Operand/opcode/result bundle between a core and the MDU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mdu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       MDUOp;
  logic             start;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output A, B, MDUOp, start, cancel,
    input  busy, HI, LO
  );

  modport slave (
    input  A, B, MDUOp, start, cancel,
    output busy, HI, LO
  );
endinterface

`default_nettype wire

// File: rtl/mdu.sv
//==============================================================================
// Module      : mdu
// Description : Multi-cycle multiply/divide unit with HI/LO registers.
//               Define MDU_MADD_EN to enable madd/maddu/msub/msubu.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic clk,
  input  wire logic reset,
  mdu_if.slave      bus
);

  localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

  localparam logic [c_cnt_w-1:0] c_mul_load = c_cnt_w'(MULT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_div_load = c_cnt_w'(DIV_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  localparam logic [3:0] c_op_mult  = 4'd1;
  localparam logic [3:0] c_op_multu = 4'd2;
  localparam logic [3:0] c_op_div   = 4'd3;
  localparam logic [3:0] c_op_divu  = 4'd4;
  localparam logic [3:0] c_op_mthi  = 4'd5;
  localparam logic [3:0] c_op_mtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] c_op_madd  = 4'd7;
  localparam logic [3:0] c_op_maddu = 4'd8;
  localparam logic [3:0] c_op_msub  = 4'd9;
  localparam logic [3:0] c_op_msubu = 4'd10;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_op;
  logic               w_latch;
  logic               w_mul_class;

  // Multiply datapath: sign-extending to 2*WIDTH makes a plain product signed-correct.
  logic [2*WIDTH-1:0] w_a_sx;
  logic [2*WIDTH-1:0] w_b_sx;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [2*WIDTH-1:0] w_mul_res;

  assign w_a_sx   = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_b_sx   = {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] w_acc;
  assign w_acc = {r_hi, r_lo};
`endif

  always_comb begin
    w_mul_res = w_prod_s;
    case (r_op)
      c_op_multu: w_mul_res = w_prod_u;
`ifdef MDU_MADD_EN
      c_op_madd:  w_mul_res = w_acc + w_prod_s;
      c_op_maddu: w_mul_res = w_acc + w_prod_u;
      c_op_msub:  w_mul_res = w_acc - w_prod_s;
      c_op_msubu: w_mul_res = w_acc - w_prod_u;
`endif
      default:    w_mul_res = w_prod_s;
    endcase
  end

  // Divide datapath: unsigned divide on magnitudes, then restore signs.
  logic             w_div_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_div_lo;
  logic [WIDTH-1:0] w_div_hi;

  assign w_div_signed = (r_op == c_op_div);
  assign w_a_neg      = w_div_signed & r_a[WIDTH-1];
  assign w_b_neg      = w_div_signed & r_b[WIDTH-1];
  assign w_a_mag      = w_a_neg ? -r_a : r_a;
  assign w_b_mag      = w_b_neg ? -r_b : r_b;
  assign w_q_mag      = w_a_mag / w_b_mag;
  assign w_r_mag      = w_a_mag % w_b_mag;

  always_comb begin
    w_div_lo = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    w_div_hi = w_a_neg ? -w_r_mag : w_r_mag;
    if (r_b == '0) begin
      w_div_lo = '1;
      w_div_hi = r_a;
    end
  end

  always_comb begin
    w_mul_class = 1'b0;
    case (bus.MDUOp)
      c_op_mult, c_op_multu: w_mul_class = 1'b1;
`ifdef MDU_MADD_EN
      c_op_madd, c_op_maddu, c_op_msub, c_op_msubu: w_mul_class = 1'b1;
`endif
      default: w_mul_class = 1'b0;
    endcase
  end

  // Cancel outranks both a new start and a completing operation.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          if (w_mul_class) begin
            w_latch     = 1'b1;
            w_state_nxt = MUL;
            w_cnt_nxt   = c_mul_load;
          end else if (bus.MDUOp == c_op_div || bus.MDUOp == c_op_divu) begin
            w_latch     = 1'b1;
            w_state_nxt = DIV;
            w_cnt_nxt   = c_div_load;
          end else if (bus.MDUOp == c_op_mthi) begin
            w_hi_nxt = bus.A;
          end else if (bus.MDUOp == c_op_mtlo) begin
            w_lo_nxt = bus.A;
          end
        end
      end
      MUL, DIV: begin
        if (bus.cancel) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          if (r_state == MUL) begin
            {w_hi_nxt, w_lo_nxt} = w_mul_res;
          end else begin
            w_hi_nxt = w_div_hi;
            w_lo_nxt = w_div_lo;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      if (w_latch) begin
        r_a  <= bus.A;
        r_b  <= bus.B;
        r_op <= bus.MDUOp;
      end
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

`default_nettype wire
